// File: rtl/cii_term_writer_pkg.sv
// Shared constants, state type and small helpers for the character-table
// write controller of the character-input display.
package cii_pkg;

    localparam int CII_COLS = 70;
    localparam int CII_ROWS = 30;
    localparam int CII_X_W  = 7;
    localparam int CII_Y_W  = 5;

    localparam logic [7:0] CII_BLANK   = 8'h00;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;

    typedef enum logic [1:0] {
        CLR_ALL,
        IDLE,
        CLR_LINE
    } cii_wr_state_t;

    // Row after y, wrapping explicitly from the last row back to the top.
    function automatic logic [CII_Y_W-1:0] cii_next_row(input logic [CII_Y_W-1:0] y,
                                                         input int rows);
        return (y == CII_Y_W'(rows - 1)) ? '0 : y + CII_Y_W'(1);
    endfunction

    function automatic logic cii_is_printable(input logic [7:0] c);
        return (c >= ASCII_SPACE) && (c <= ASCII_TILDE);
    endfunction

endpackage

// File: rtl/cii_term_writer_if.sv
// Keyboard-to-controller code stream: valid/ready handshake carrying one
// ASCII code per transfer.
interface cii_term_writer_if;

    logic       in_valid;
    logic [7:0] in_ascii;
    logic       in_ready;

    modport master (output in_valid, output in_ascii, input in_ready);
    modport slave  (input in_valid, input in_ascii, output in_ready);

endinterface

// File: rtl/cii_term_writer_sweeper.sv
// Cell sweep generator shared by full-screen and single-row clears; start
// presents the first cell in the same cycle so a clear begins without a bubble.
module cii_clear_sweeper
    import cii_pkg::*;
#(
    parameter int COLS = CII_COLS,
    parameter int ROWS = CII_ROWS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               step_i,
    input  logic               row_mode_i,
    input  logic [CII_Y_W-1:0] start_row_i,
    output logic [CII_X_W-1:0] x_o,
    output logic [CII_Y_W-1:0] y_o,
    output logic               done_o
);

    logic [CII_X_W-1:0] x_q, x_d;
    logic [CII_Y_W-1:0] y_q, y_d;
    logic               row_mode_q, row_mode_d;
    logic               cur_mode;
    logic               last_col;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path infers a latch.
        x_d        = x_q;
        y_d        = y_q;
        row_mode_d = row_mode_q;

        x_o      = start_i ? '0 : x_q;
        y_o      = start_i ? (row_mode_i ? start_row_i : '0) : y_q;
        cur_mode = start_i ? row_mode_i : row_mode_q;
        last_col = (x_o == CII_X_W'(COLS - 1));
        done_o   = last_col && (cur_mode || (y_o == CII_Y_W'(ROWS - 1)));

        if (start_i) begin
            row_mode_d = row_mode_i;
        end
        if (step_i) begin
            x_d = last_col ? '0 : x_o + CII_X_W'(1);
            y_d = last_col ? cii_next_row(y_o, ROWS) : y_o;
        end else if (start_i) begin
            x_d = x_o;
            y_d = y_o;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            row_mode_q <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            row_mode_q <= row_mode_d;
        end
    end

endmodule

// File: rtl/cii_term_writer.sv
// Sole master of the character-table write port: decodes keyboard codes,
// keeps the text cursor and sequences screen/line clears and backspace erase.
module cii_term_writer
    import cii_pkg::*;
#(
    parameter int         COLS  = CII_COLS,
    parameter int         ROWS  = CII_ROWS,
    parameter logic [7:0] BLANK = CII_BLANK
) (
    input  logic               clk,
    input  logic               rst,
    cii_term_writer_if.slave   key_if,
    output logic               we,
    output logic [CII_X_W-1:0] char_x_we,
    output logic [CII_Y_W-1:0] char_y_we,
    output logic [7:0]         ascii_we,
    output logic [CII_X_W-1:0] cursor_x,
    output logic [CII_Y_W-1:0] cursor_y,
    output logic               busy
);

    localparam logic [CII_X_W-1:0] X_LAST = CII_X_W'(COLS - 1);

    cii_wr_state_t      state_q, state_d;
    logic               we_q, we_d;
    logic [CII_X_W-1:0] wx_q, wx_d;
    logic [CII_Y_W-1:0] wy_q, wy_d;
    logic [7:0]         wd_q, wd_d;
    logic [CII_X_W-1:0] cx_q, cx_d;
    logic [CII_Y_W-1:0] cy_q, cy_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;

    logic               sw_start, sw_step, sw_row_mode, sw_done;
    logic [CII_Y_W-1:0] sw_row, sw_y;
    logic [CII_X_W-1:0] sw_x;
    logic               accept;

    cii_clear_sweeper #(.COLS(COLS), .ROWS(ROWS)) u_sweeper (
        .clk         (clk),
        .rst         (rst),
        .start_i     (sw_start),
        .step_i      (sw_step),
        .row_mode_i  (sw_row_mode),
        .start_row_i (sw_row),
        .x_o         (sw_x),
        .y_o         (sw_y),
        .done_o      (sw_done)
    );

    assign accept = key_if.in_valid && rdy_q;

    always_comb begin
        state_d     = state_q;
        we_d        = 1'b0;
        wx_d        = wx_q;
        wy_d        = wy_q;
        wd_d        = wd_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        sw_start    = 1'b0;
        sw_step     = 1'b0;
        sw_row_mode = 1'b1;
        sw_row      = cii_next_row(cy_q, ROWS);

        case (state_q)
            CLR_ALL, CLR_LINE: begin
                sw_step = 1'b1;
                we_d    = 1'b1;
                wx_d    = sw_x;
                wy_d    = sw_y;
                wd_d    = BLANK;
                if (sw_done) begin
                    state_d = IDLE;
                    if (state_q == CLR_ALL) begin
                        cx_d = '0;
                        cy_d = '0;
                    end
                end
            end
            IDLE: begin
                if (accept) begin
                    if (cii_is_printable(key_if.in_ascii)) begin
                        we_d = 1'b1;
                        wx_d = cx_q;
                        wy_d = cy_q;
                        wd_d = key_if.in_ascii;
                        if (cx_q == X_LAST) begin
                            // Own cell is written now; the sweeper is only armed,
                            // so the line clear follows one cycle later.
                            cx_d     = '0;
                            cy_d     = sw_row;
                            sw_start = 1'b1;
                            state_d  = CLR_LINE;
                        end else begin
                            cx_d = cx_q + CII_X_W'(1);
                        end
                    end else begin
                        case (key_if.in_ascii)
                            ASCII_LF, ASCII_CR: begin
                                cx_d     = '0;
                                cy_d     = sw_row;
                                sw_start = 1'b1;
                                sw_step  = 1'b1;
                                we_d     = 1'b1;
                                wx_d     = sw_x;
                                wy_d     = sw_y;
                                wd_d     = BLANK;
                                state_d  = CLR_LINE;
                            end
                            ASCII_BS: begin
                                if (cx_q != '0) begin
                                    cx_d = cx_q - CII_X_W'(1);
                                    we_d = 1'b1;
                                    wx_d = cx_q - CII_X_W'(1);
                                    wy_d = cy_q;
                                    wd_d = BLANK;
                                end else if (cy_q != '0) begin
                                    cx_d = X_LAST;
                                    cy_d = cy_q - CII_Y_W'(1);
                                    we_d = 1'b1;
                                    wx_d = X_LAST;
                                    wy_d = cy_q - CII_Y_W'(1);
                                    wd_d = BLANK;
                                end
                            end
                            ASCII_FF: begin
                                sw_start    = 1'b1;
                                sw_row_mode = 1'b0;
                                sw_step     = 1'b1;
                                we_d        = 1'b1;
                                wx_d        = sw_x;
                                wy_d        = sw_y;
                                wd_d        = BLANK;
                                state_d     = CLR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = CLR_ALL;
        endcase

        rdy_d  = (state_d == IDLE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLR_ALL;
            we_q    <= 1'b0;
            wx_q    <= '0;
            wy_q    <= '0;
            wd_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            wx_q    <= wx_d;
            wy_q    <= wy_d;
            wd_q    <= wd_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
        end
    end

    assign key_if.in_ready = rdy_q;
    assign we        = we_q;
    assign char_x_we = wx_q;
    assign char_y_we = wy_q;
    assign ascii_we  = wd_q;
    assign cursor_x  = cx_q;
    assign cursor_y  = cy_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cii_term_writer.sv
// Self-checking bench for cii_term_writer: a screen/cursor model predicts every
// table write with its cycle, checked against the observed write port.
module tb_cii_term_writer;
    import cii_pkg::*;

    localparam int COLS = CII_COLS;
    localparam int ROWS = CII_ROWS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we;
    logic [6:0] char_x_we, cursor_x;
    logic [4:0] char_y_we, cursor_y;
    logic [7:0] ascii_we;
    logic       busy;

    cii_term_writer_if key_if ();

    cii_term_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(CII_BLANK)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_if    (key_if),
        .we        (we),
        .char_x_we (char_x_we),
        .char_y_we (char_y_we),
        .ascii_we  (ascii_we),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int x;
        int y;
        int d;
        int cyc;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] scr     [ROWS][COLS];
    logic [7:0] dut_scr [ROWS][COLS];
    int mcx = 0, mcy = 0, busy_until = 0, nxt = 0;
    int n_err = 0, n_chk = 0, wr_cnt = 0;
    bit mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    task automatic push(input int x, input int y, input int d);
        exp_q.push_back('{x, y, d, nxt});
        scr[y][x] = 8'(d);
        nxt++;
    endtask

    task automatic push_line(input int y);
        for (int x = 0; x < COLS; x++) push(x, y, 0);
        busy_until = nxt - 1;
    endtask

    task automatic push_all();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) push(x, y, 0);
        busy_until = nxt - 1;
        mcx = 0;
        mcy = 0;
    endtask

    task automatic model_accept(input logic [7:0] c, input int t);
        nxt = t + 1;
        if (c >= 8'h20 && c <= 8'h7E) begin
            push(mcx, mcy, int'(c));
            if (mcx == COLS - 1) begin
                mcx = 0;
                mcy = (mcy + 1) % ROWS;
                push_line(mcy);
            end else begin
                mcx++;
            end
        end else if (c == 8'h0A || c == 8'h0D) begin
            mcx = 0;
            mcy = (mcy + 1) % ROWS;
            push_line(mcy);
        end else if (c == 8'h08) begin
            if (mcx > 0) begin
                mcx--;
                push(mcx, mcy, 0);
            end else if (mcy > 0) begin
                mcx = COLS - 1;
                mcy--;
                push(mcx, mcy, 0);
            end
        end else if (c == 8'h0C) begin
            push_all();
        end
    endtask

    // ---------------- write-port monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy_vs_ready", busy, !key_if.in_ready);
            if (we === 1'b1) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check("we_unexpected", we, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_x", char_x_we, mon_e.x);
                    check("wr_y", char_y_we, mon_e.y);
                    check("wr_data", ascii_we, mon_e.d);
                    check("wr_cycle", cyc, mon_e.cyc);
                end
                if (char_x_we < COLS && char_y_we < ROWS) dut_scr[char_y_we][char_x_we] = ascii_we;
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                check("we_missing", we, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc_drive(input bit v, input logic [7:0] code, output bit acc);
        key_if.in_valid = v;
        key_if.in_ascii = code;
        check("in_ready", key_if.in_ready, (cyc >= busy_until));
        acc = v && (cyc >= busy_until);
        if (acc) model_accept(code, cyc);
        tick();
    endtask

    task automatic wait_ready();
        int k = 0;
        while (key_if.in_ready !== 1'b1 && k < 5000) begin
            tick();
            k++;
        end
        check("ready_rise_cycle", cyc, busy_until);
    endtask

    task automatic send(input logic [7:0] code);
        bit acc = 1'b0;
        int k = 0;
        while (!acc && k < 6000) begin
            cyc_drive(1'b1, code, acc);
            k++;
        end
        key_if.in_valid = 1'b0;
        if (busy_until > cyc - 1) wait_ready();
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_cursor_x"}, cursor_x, mcx);
        check({tag, "_cursor_y"}, cursor_y, mcy);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"}, we, 0);
        check({tag, "_char_x_we"}, char_x_we, 0);
        check({tag, "_char_y_we"}, char_y_we, 0);
        check({tag, "_ascii_we"}, ascii_we, 0);
        check({tag, "_cursor_x"}, cursor_x, 0);
        check({tag, "_cursor_y"}, cursor_y, 0);
        check({tag, "_in_ready"}, key_if.in_ready, 0);
        check({tag, "_busy"}, busy, 1);
    endtask

    task automatic full_clear_after_reset(input string tag);
        int base = wr_cnt;
        nxt = cyc + 1;
        push_all();
        rst = 1'b0;
        wait_ready();
        check({tag, "_write_count"}, wr_cnt - base, COLS * ROWS);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check_cursor(tag);
    endtask

    task automatic compare_screen(input string tag);
        int diffs = 0;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                if (scr[y][x] !== dut_scr[y][x]) diffs++;
        check(tag, diffs, 0);
    endtask

    function automatic logic [7:0] rand_code();
        int r = $urandom_range(0, 99);
        logic [7:0] c;
        if (r < 70) return 8'($urandom_range(32, 126));
        if (r < 82) return ASCII_BS;
        if (r < 86) return ASCII_LF;
        if (r < 90) return ASCII_CR;
        do c = 8'($urandom_range(0, 255));
        while ((c >= 8'h20 && c <= 8'h7E) || c == 8'h08 || c == 8'h0A || c == 8'h0C || c == 8'h0D);
        return c;
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        bit         acc;
        bit         have;
        logic [7:0] code;
        int         base;

        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                scr[y][x]     = 8'hFF;
                dut_scr[y][x] = 8'hFF;
            end
        key_if.in_valid = 1'b0;
        key_if.in_ascii = 8'h00;

        repeat (3) tick();
        mon_en = 1'b1;
        tick();
        check_reset_values("reset");

        full_clear_after_reset("power_on_clear");
        compare_screen("power_on_screen");

        send(8'h41);
        send(8'h42);
        check_cursor("ab");

        repeat (5) send(ASCII_LF);
        check_cursor("row5");
        for (int i = 0; i < COLS - 1; i++) send(8'($urandom_range(32, 126)));
        check_cursor("col69");
        send(8'h43);
        check_cursor("wrap");
        check("wrap_queue_empty", exp_q.size(), 0);

        repeat (23) send(ASCII_LF);
        repeat (3) send(8'($urandom_range(32, 126)));
        check_cursor("row29");
        send(ASCII_CR);
        check_cursor("cr_wrap_top");

        repeat (2) send(ASCII_LF);
        send(ASCII_BS);
        check_cursor("bs_row_back");
        send(ASCII_FF);
        check_cursor("ff_clear");
        compare_screen("ff_screen");
        base = wr_cnt;
        send(ASCII_BS);
        send(8'h07);
        repeat (3) tick();
        check("bs_origin_no_write", wr_cnt, base);
        check_cursor("bs_origin");

        have = 1'b0;
        code = 8'h00;
        for (int i = 0; i < 1500; i++) begin
            if (!have && $urandom_range(0, 9) < 8) begin
                have = 1'b1;
                code = rand_code();
            end
            cyc_drive(have, code, acc);
            if (acc) have = 1'b0;
        end
        key_if.in_valid = 1'b0;
        while (cyc < busy_until) tick();
        tick();
        check_cursor("random");
        check("random_queue_empty", exp_q.size(), 0);
        compare_screen("random_screen");

        cyc_drive(1'b1, ASCII_LF, acc);
        key_if.in_valid = 1'b0;
        repeat (29) tick();
        check("pre_abort_x", char_x_we, 29);
        rst = 1'b1;
        while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
        tick();
        check("abort_we_low", we, 0);
        tick();
        check_reset_values("abort");
        full_clear_after_reset("restart_clear");
        compare_screen("restart_screen");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
